dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles port 1 may wait while port 0 is granted before port 1 is forced.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: data memory depth in 32-bit words, used by the address check.
REQ-003 SHALL have ports `clk` (input, 1, sole clock, rising edge) and `rst_n` (input, 1, asynchronous active-low reset).
REQ-004 SHALL have ports `p0_valid` (input, 1, CPU request) and `p0_ready` (output, 1, CPU request accepted this cycle).
REQ-005 SHALL have ports `p0_we` (input, 1, 1=store 0=load), `p0_addr` (input, 32, byte address) and `p0_wdata` (input, 32, store data).
REQ-006 SHALL have ports `p0_rsp_valid` (output, 1), `p0_rsp_rdata` (output, 32) and `p0_rsp_err` (output, 1).
REQ-007 SHALL have port-1 (loader/debug) signals `p1_valid`, `p1_ready`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_rsp_valid`, `p1_rsp_rdata` and `p1_rsp_err`, with the same directions, widths and meanings as port 0.
REQ-008 SHALL have memory-side ports `mem_we` (output, 1), `mem_re` (output, 1), `mem_addr` (output, 32, byte address, word index = [31:2]), `mem_wdata` (output, 32) and `mem_rdata` (input, 32, combinational read of `mem_addr`).

Function
REQ-009 SHALL grant at most one port per cycle; a handshake completes in cycle T when `pX_valid` and `pX_ready` are both 1.
REQ-010 SHALL assert `pX_ready` combinationally in the cycle the grant is given, with no dependence of `pX_ready` on its own `pX_ready`.
REQ-011 SHALL drive `mem_addr`, `mem_wdata`, `mem_we`=`we` and `mem_re`=!`we` from the granted port; with no grant, `mem_we`=`mem_re`=0 and `mem_addr`/`mem_wdata`=0.
REQ-012 SHALL prioritise port 0 when both ports are valid, unless the starvation counter equals STARVE_LIMIT, in which case port 1 is granted.
REQ-013 SHALL increment a starvation counter, saturating at STARVE_LIMIT, each cycle `p1_valid`=1 and port 0 is granted, and clear it on any port-1 grant or any cycle `p1_valid`=0.
REQ-014 SHALL give every accepted request, load or store, exactly one response: `pX_rsp_valid`=1 for one cycle in T+1.
REQ-015 SHALL register the `mem_rdata` captured at the end of T into `pX_rsp_rdata` for loads, and drive `pX_rsp_rdata`=0 for stores.
REQ-016 SHALL let the memory commit a store at the rising edge ending T; a load to the same address in T+1 returns the new data.
REQ-017 SHALL sustain one accepted request per cycle, with back-to-back grants to the same or alternating ports allowed.
REQ-018 SHALL NOT apply backpressure on responses; requesters always accept the response.
REQ-019 SHALL hold `pX_rsp_rdata` at its last value when `pX_rsp_valid`=0.

Reset
REQ-020 SHALL, while `rst_n`=0, force `pX_ready`, `pX_rsp_valid`, `pX_rsp_err`, `mem_we` and `mem_re` to 0, `pX_rsp_rdata` to 0 and the starvation counter to 0.
REQ-021 SHALL discard any response due in the cycle after an accepted request if reset asserts between them.
REQ-022 SHALL grant nothing in the first cycle after deassertion, and issue no spurious write when `rst_n` deasserts.

Configuration
REQ-023 SHALL, with macro DMEM_ARB_ADDR_CHECK_EN defined, treat a request with addr[1:0]!=0 or addr>=4*DEPTH_WORDS as follows: accept it, force `mem_we`=`mem_re`=0, then respond in T+1 with `pX_rsp_err`=1 and `pX_rsp_rdata`=0.
REQ-024 SHALL, without DMEM_ARB_ADDR_CHECK_EN, issue every request unchecked and tie `pX_rsp_err` to 0.

Structure
REQ-025 SHALL place the port-index constants, the response-record typedef {valid, err, rdata} and the default STARVE_LIMIT in the shared package `dmem_arb_pkg`.
REQ-026 SHALL implement the grant selection plus starvation counter as a single sub-module, `dmem_arb_sel`; the response registers stay in the top module.

Verification
REQ-027 SHALL cover: p0 store addr 0x10 data 0xDEADBEEF, then p0 load 0x10 in the next cycle -> p0_rsp_valid in the cycle after the load, with rdata=0xDEADBEEF.
REQ-028 SHALL cover: both ports valid every cycle for 12 cycles with STARVE_LIMIT=4 -> grant pattern p0,p0,p0,p0,p1 repeating, with no port-1 wait exceeding 4 cycles.
REQ-029 SHALL cover: p1 load 0x20 alone -> p1_ready=1 the same cycle, p1_rsp_valid next cycle, and p0_rsp_valid stays 0.
REQ-030 SHALL cover: with the macro defined, p0 store to 0x13 and p1 load 0x1000 -> each rsp_err=1, rsp_rdata=0, mem_we=mem_re=0; without the macro, the store writes and err=0.
REQ-031 SHALL cover: rst_n asserted in the cycle after p0 load acceptance -> no p0_rsp_valid, all outputs 0, counter 0, and the first grant two cycles after deassertion.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   P0 / P1          : port index constants (P0 = CPU, P1 = loader/debug)
//   STARVE_LIMIT_DEF : default number of cycles port 1 may wait behind port 0
//   rsp_t            : per-port response record {valid, err, rdata}
package dmem_arb_pkg;

    localparam int P0               = 0;
    localparam int P1               = 1;
    localparam int NUM_PORTS        = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Grant selection for the two-port data-memory arbiter.
// Port 0 wins ties unless port 1 has already waited STARVE_LIMIT cycles.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   reqValid[i] : port i is requesting
//   gnt[i]      : port i is granted this cycle (one-hot or zero)
module dmem_arb_sel
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] reqValid,
    output logic [NUM_PORTS-1:0] gnt
);

    // +2 keeps the width legal for STARVE_LIMIT = 0.
    localparam int CW = $clog2(STARVE_LIMIT + 2);

    logic [CW-1:0] starveCnt;
    logic [1:0]    enPipe;
    logic          starved;

    assign starved = (starveCnt == CW'(STARVE_LIMIT));

    // Grants open two cycles after reset release, so nothing is issued
    // while the rest of the system is still coming out of reset.
    always_comb begin
        gnt = '0;
        if (enPipe[1]) begin
            if (reqValid[P1] && (!reqValid[P0] || starved))
                gnt[P1] = 1'b1;
            else if (reqValid[P0])
                gnt[P0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enPipe    <= '0;
            starveCnt <= '0;
        end else begin
            enPipe <= {enPipe[0], 1'b1};
            if (!reqValid[P1] || gnt[P1])
                starveCnt <= '0;
            else if (gnt[P0] && !starved)
                starveCnt <= starveCnt + CW'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Port 0 (CPU) has priority; port 1 (loader/debug) is protected from
// starvation. Every accepted request gets one response the next cycle.
// Optional macro DMEM_ARB_ADDR_CHECK_EN: misaligned or out-of-range
// requests are accepted but not issued, and answered with err=1, rdata=0.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   pX_valid/ready/we/addr/wdata    : request channel of port X
//   pX_rsp_valid/rsp_rdata/rsp_err  : response channel of port X (no backpressure)
//   mem_we/re/addr/wdata, mem_rdata : memory side (combinational read)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int DEPTH_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [NUM_PORTS-1:0]       reqValid, reqWe, gnt, addrBad;
    logic [NUM_PORTS-1:0][31:0] reqAddr, reqWdata;
    rsp_t [NUM_PORTS-1:0]       rspQ;

    assign reqValid = {p1_valid, p0_valid};
    assign reqWe    = {p1_we,    p0_we};
    assign reqAddr  = {p1_addr,  p0_addr};
    assign reqWdata = {p1_wdata, p0_wdata};

    dmem_arb_sel #(.STARVE_LIMIT(STARVE_LIMIT)) uSel (
        .clk      (clk),
        .rst_n    (rst_n),
        .reqValid (reqValid),
        .gnt      (gnt)
    );

    assign p0_ready = gnt[P0];
    assign p1_ready = gnt[P1];

`ifdef DMEM_ARB_ADDR_CHECK_EN
    // 33-bit compare so a DEPTH_WORDS of 2^30 cannot wrap.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : gChk
        assign addrBad[i] = (reqAddr[i][1:0] != 2'b00) ||
                            ({1'b0, reqAddr[i]} >= (33'(DEPTH_WORDS) << 2));
    end
`else
    assign addrBad = '0;
`endif

    // Memory-side mux; a rejected address still completes the handshake
    // but never touches the memory.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt[i]) begin
                mem_addr  = reqAddr[i];
                mem_wdata = reqWdata[i];
                mem_we    = reqWe[i]  && !addrBad[i];
                mem_re    = !reqWe[i] && !addrBad[i];
            end
        end
    end

    // Responses: one-cycle pulse after acceptance; rdata only moves on a grant
    // so it holds between responses. Async reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspQ <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rspQ[i].valid <= gnt[i];
                rspQ[i].err   <= gnt[i] && addrBad[i];
                if (gnt[i])
                    rspQ[i].rdata <= (reqWe[i] || addrBad[i]) ? 32'h0 : mem_rdata;
            end
        end
    end

    assign p0_rsp_valid = rspQ[P0].valid;
    assign p0_rsp_err   = rspQ[P0].err;
    assign p0_rsp_rdata = rspQ[P0].rdata;
    assign p1_rsp_valid = rspQ[P1].valid;
    assign p1_rsp_err   = rspQ[P1].err;
    assign p1_rsp_rdata = rspQ[P1].rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// starvation / address-check / reset sequences, then randomized traffic
// against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
    logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] memInit(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory attached to the DUT: combinational read, write at the clock edge.
    logic [31:0] mem [0:DEPTH-1];
    logic        loadMem = 1'b1;
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (loadMem) for (int i = 0; i < DEPTH; i++) mem[i] <= memInit(i);
        else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end

    int nTests = 0;
    int nFail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %0s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
        p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    endtask

    // One bench cycle: drive at the falling edge, sample 1 ns later.
    task automatic step(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
        @(negedge clk);
        drv(v0, we0, a0, d0, v1, we1, a1, d1);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic v0, we0; logic [31:0] a0, d0;
        logic v1, we1; logic [31:0] a1, d1;
        logic eR0, eR1, eV0, eV1;
        logic [31:0] eD0, eD1;
    } vec_t;

    vec_t tbl [9];

    // Reference model state for the random phase.
    logic [31:0] refMem [0:DEPTH-1];
    int          waitCnt;
    logic        pendV0, pendV1;
    logic [31:0] pendD0, pendD1;

    initial begin
        for (int i = 0; i < DEPTH; i++) refMem[i] = memInit(i);

        tbl[0] = '{1,1,32'h10,32'hDEADBEEF, 0,0,0,0,           1,0, 0,0, 32'h0,        32'h0};
        tbl[1] = '{1,0,32'h10,0,            0,0,0,0,           1,0, 1,0, 32'h0,        32'h0};
        tbl[2] = '{0,0,0,0,                 0,0,0,0,           0,0, 1,0, 32'hDEADBEEF, 32'h0};
        tbl[3] = '{0,0,0,0,                 1,0,32'h20,0,      0,1, 0,0, 32'hDEADBEEF, 32'h0};
        tbl[4] = '{0,0,0,0,                 0,0,0,0,           0,0, 0,1, 32'hDEADBEEF, memInit(8)};
        tbl[5] = '{0,0,0,0,                 1,1,32'h24,32'h12345678, 0,1, 0,0, 32'hDEADBEEF, memInit(8)};
        tbl[6] = '{1,0,32'h24,0,            1,0,32'h10,0,      1,0, 0,1, 32'hDEADBEEF, 32'h0};
        tbl[7] = '{0,0,0,0,                 0,0,0,0,           0,0, 1,0, 32'h12345678, 32'h0};
        tbl[8] = '{0,0,0,0,                 0,0,0,0,           0,0, 0,0, 32'h12345678, 32'h0};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        loadMem = 1'b0;
        #1;
        chk("reset_p0_ready", {31'b0, p0_ready}, 0);
        chk("reset_p1_ready", {31'b0, p1_ready}, 0);
        chk("reset_mem_we", {31'b0, mem_we}, 0);
        chk("reset_mem_re", {31'b0, mem_re}, 0);
        chk("reset_p0_rsp_valid", {31'b0, p0_rsp_valid}, 0);
        chk("reset_p1_rdata", p1_rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();

        // ---------------- directed table ----------------
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].v0, tbl[k].we0, tbl[k].a0, tbl[k].d0, tbl[k].v1, tbl[k].we1, tbl[k].a1, tbl[k].d1);
            chk($sformatf("tbl%0d_p0_ready", k), {31'b0, p0_ready}, {31'b0, tbl[k].eR0});
            chk($sformatf("tbl%0d_p1_ready", k), {31'b0, p1_ready}, {31'b0, tbl[k].eR1});
            chk($sformatf("tbl%0d_p0_rsp_valid", k), {31'b0, p0_rsp_valid}, {31'b0, tbl[k].eV0});
            chk($sformatf("tbl%0d_p1_rsp_valid", k), {31'b0, p1_rsp_valid}, {31'b0, tbl[k].eV1});
            chk($sformatf("tbl%0d_p0_rdata", k), p0_rsp_rdata, tbl[k].eD0);
            chk($sformatf("tbl%0d_p1_rdata", k), p1_rsp_rdata, tbl[k].eD1);
            chk($sformatf("tbl%0d_mem_we", k), {31'b0, mem_we},
                {31'b0, (tbl[k].eR0 & tbl[k].we0) | (tbl[k].eR1 & tbl[k].we1)});
            chk($sformatf("tbl%0d_errs", k), {30'b0, p1_rsp_err, p0_rsp_err}, 0);
        end

        // ---------------- starvation: both valid for 12 cycles ----------------
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
            chk($sformatf("starve%0d_p0_ready", i), {31'b0, p0_ready}, {31'b0, (i % 5) != 4});
            chk($sformatf("starve%0d_p1_ready", i), {31'b0, p1_ready}, {31'b0, (i % 5) == 4});
        end
        idle();
        idle();

        // ---------------- address check ----------------
`ifdef DMEM_ARB_ADDR_CHECK_EN
        step(1, 1, 32'h13, 32'hCAFEF00D, 0, 0, 0, 0);
        chk("ac_st_ready", {31'b0, p0_ready}, 1);
        chk("ac_st_memwe", {31'b0, mem_we}, 0);
        chk("ac_st_memre", {31'b0, mem_re}, 0);
        step(0, 0, 0, 0, 1, 0, 32'h1000, 0);
        chk("ac_ld_ready", {31'b0, p1_ready}, 1);
        chk("ac_ld_memre", {31'b0, mem_re}, 0);
        chk("ac_ld_memwe", {31'b0, mem_we}, 0);
        chk("ac_st_rsp", {30'b0, p0_rsp_valid, p0_rsp_err}, 32'h3);
        chk("ac_st_rdata", p0_rsp_rdata, 0);
        idle();
        chk("ac_ld_rsp", {30'b0, p1_rsp_valid, p1_rsp_err}, 32'h3);
        chk("ac_ld_rdata", p1_rsp_rdata, 0);
`else
        step(1, 1, 32'h13, 32'hCAFEF00D, 0, 0, 0, 0);
        chk("ac_st_ready", {31'b0, p0_ready}, 1);
        chk("ac_st_memwe", {31'b0, mem_we}, 1);
        chk("ac_st_addr", mem_addr, 32'h13);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0);
        chk("ac_st_rsp", {30'b0, p0_rsp_valid, p0_rsp_err}, 32'h2);
        chk("ac_rd_memre", {31'b0, mem_re}, 1);
        step(0, 0, 0, 0, 1, 0, 32'h1000, 0);
        chk("ac_rd_rdata", p0_rsp_rdata, 32'hCAFEF00D);
        chk("ac_ld_memre", {31'b0, mem_re}, 1);
        idle();
        chk("ac_ld_rsp", {30'b0, p1_rsp_valid, p1_rsp_err}, 32'h2);
`endif
        idle();

        // ---------------- reset after a load is accepted ----------------
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
            chk($sformatf("rst_pre%0d_p0_ready", i), {31'b0, p0_ready}, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ready", {30'b0, p1_ready, p0_ready}, 0);
        chk("rst_async_memre", {31'b0, mem_re}, 0);
        @(negedge clk); #1;
        chk("rst_no_rsp", {30'b0, p1_rsp_valid, p0_rsp_valid}, 0);
        chk("rst_rdata0", p0_rsp_rdata, 0);
        chk("rst_rdata1", p1_rsp_rdata, 0);
        chk("rst_err", {30'b0, p1_rsp_err, p0_rsp_err}, 0);
        chk("rst_mem", {30'b0, mem_we, mem_re}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_cycA_ready", {30'b0, p1_ready, p0_ready}, 0);
        chk("rel_cycA_mem", {30'b0, mem_we, mem_re}, 0);
        step(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
        chk("rel_cycB_ready", {30'b0, p1_ready, p0_ready}, 0);
        // Counter must have been cleared: four p0 grants before port 1 is forced.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
            chk($sformatf("rel%0d_p0_ready", i), {31'b0, p0_ready}, {31'b0, (i % 5) != 4});
            chk($sformatf("rel%0d_p1_ready", i), {31'b0, p1_ready}, {31'b0, (i % 5) == 4});
        end
        idle();
        idle();

        // ---------------- randomized traffic vs. model ----------------
        waitCnt = 0;
        pendV0 = 0; pendV1 = 0; pendD0 = 0; pendD1 = 0;
        for (int c = 0; c < 400; c++) begin
            logic v0, v1, w0, w1, g0, g1;
            logic [31:0] a0, a1, d0, d1;
            v0 = 1'($urandom_range(0, 3) != 0);
            v1 = 1'($urandom_range(0, 1));
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = 32'(256 + 4 * $urandom_range(0, 15));
            a1 = 32'(256 + 4 * $urandom_range(0, 15));
            d0 = $urandom;
            d1 = $urandom;
            step(v0, w0, a0, d0, v1, w1, a1, d1);

            chk("rnd_p0_rsp_valid", {31'b0, p0_rsp_valid}, {31'b0, pendV0});
            chk("rnd_p1_rsp_valid", {31'b0, p1_rsp_valid}, {31'b0, pendV1});
            if (pendV0) chk("rnd_p0_rdata", p0_rsp_rdata, pendD0);
            if (pendV1) chk("rnd_p1_rdata", p1_rsp_rdata, pendD1);

            // Port 1 is served when alone, or once it has waited LIMIT cycles.
            g1 = v1 && (!v0 || waitCnt == LIMIT);
            g0 = v0 && !g1;
            chk("rnd_p0_ready", {31'b0, p0_ready}, {31'b0, g0});
            chk("rnd_p1_ready", {31'b0, p1_ready}, {31'b0, g1});
            chk("rnd_mem_we", {31'b0, mem_we}, {31'b0, (g0 && w0) || (g1 && w1)});
            chk("rnd_mem_re", {31'b0, mem_re}, {31'b0, (g0 && !w0) || (g1 && !w1)});
            chk("rnd_mem_addr", mem_addr, g0 ? a0 : (g1 ? a1 : 32'h0));

            pendV0 = g0;
            pendV1 = g1;
            if (g0) begin
                pendD0 = w0 ? 32'h0 : refMem[a0 / 4];
                if (w0) refMem[a0 / 4] = d0;
            end
            if (g1) begin
                pendD1 = w1 ? 32'h0 : refMem[a1 / 4];
                if (w1) refMem[a1 / 4] = d1;
            end
            if (!v1 || g1) waitCnt = 0;
            else if (g0 && waitCnt < LIMIT) waitCnt++;
            if (waitCnt > LIMIT) chk("rnd_wait_bound", 32'(waitCnt), LIMIT);
        end
        idle();
        chk("rnd_last_p0_valid", {31'b0, p0_rsp_valid}, {31'b0, pendV0});
        chk("rnd_last_p1_valid", {31'b0, p1_rsp_valid}, {31'b0, pendV1});

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
